// File: rtl/nn_serial_pkg.sv
// Shared definitions for the serial pixel link (transmitter, receiver, benches).
//   serialState_t : transmitter FSM states
//   ONE, HALF     : Q8.8 fixed-point constants 1.0 and 0.5
package nn_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } serialState_t;

  localparam logic signed [15:0] ONE  = 16'sh0100;
  localparam logic signed [15:0] HALF = 16'sh0080;

endpackage

// File: rtl/serial_image_transmitter_if.sv
// Frame handshake between a host and serial_image_transmitter.
//   start  : frame valid, accepted when ready=1
//   dataIn : numInputs pixels of dataWidth bits, pixel i at [dataWidth*i +: dataWidth]
//   ready  : transmitter idle and able to accept
//   busy   : inverse of ready
//   done   : one-cycle pulse at end of frame
interface serial_image_transmitter_if #(
  parameter int numInputs = 784,
  parameter int dataWidth = 16
);
  logic                           start;
  logic [numInputs*dataWidth-1:0] dataIn;
  logic                           ready;
  logic                           busy;
  logic                           done;

  modport master (output start, output dataIn, input ready, input busy, input done);
  modport slave  (input start, input dataIn, output ready, output busy, output done);
endinterface

// File: rtl/serial_image_transmitter_serialPhaseTimer.sv
// Half-period timer for the serial link.
//   clock, reset   : system clock, synchronous active-high reset
//   restart        : reload the counter (asserted on the edge entering a new state)
//   halfPeriodTick : high in the last cycle of every clkDiv-cycle half period
module serialPhaseTimer #(
  parameter int clkDiv = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic halfPeriodTick
);

  localparam int cntWidth = (clkDiv > 1) ? $clog2(clkDiv) : 1;
  localparam logic [cntWidth-1:0] reload = cntWidth'(clkDiv - 1);

  logic [cntWidth-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (restart || count == '0) begin
      count <= reload;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign halfPeriodTick = (count == '0);

endmodule

// File: rtl/serial_image_transmitter.sv
// Sending end of the serial pixel link. Accepts one frame, binarizes each pixel
// against threshold and shifts the bits out MSB first (pixel numInputs-1 first).
//   clock, reset : system clock, synchronous active-high reset
//   host         : start/dataIn/ready/busy/done frame handshake (slave side)
//   serialReset  : receiver clear, high for 2*clkDiv cycles after acceptance
//   serialClock  : link clock, clkDiv cycles low then clkDiv cycles high per bit
//   serialData   : link data, changes only while serialClock is low
module serial_image_transmitter
  import nn_serial_pkg::*;
#(
  parameter int numInputs     = 784,
  parameter int dataWidth     = 16,
  parameter int dataFracWidth = 8,
  parameter int dataIntWidth  = 8,
  parameter int clkDiv        = 4,
  parameter logic signed [dataWidth-1:0] threshold = HALF
) (
  input  logic                        clock,
  input  logic                        reset,
  serial_image_transmitter_if.slave   host,
  output logic                        serialReset,
  output logic                        serialClock,
  output logic                        serialData
);

  if (dataIntWidth + dataFracWidth != dataWidth) begin : gFormatCheck
    $error("dataIntWidth + dataFracWidth must equal dataWidth");
  end
  if (clkDiv < 1) begin : gDivCheck
    $error("clkDiv must be at least 1");
  end

  localparam int bitCntWidth = $clog2(numInputs + 1);
  localparam logic [bitCntWidth-1:0] lastBit = bitCntWidth'(numInputs - 1);

  serialState_t           state, stateNext;
  logic                   highPhase, highPhaseNext;
  logic [bitCntWidth-1:0] bitCount, bitCountNext;
  logic [numInputs-1:0]   shiftReg, shiftNext;
  logic [numInputs-1:0]   frameBits;
  logic                   halfPeriodTick;
  logic                   restart;
  logic                   doneReg;

  always_comb begin
    frameBits = '0;
    for (int unsigned i = 0; i < numInputs; i++) begin
      frameBits[i] = $signed(host.dataIn[dataWidth*i +: dataWidth]) >= threshold;
    end
  end

  serialPhaseTimer #(.clkDiv(clkDiv)) uTimer (
    .clock          (clock),
    .reset          (reset),
    .restart        (restart),
    .halfPeriodTick (halfPeriodTick)
  );

  // CLEAR reuses highPhase to count its two half periods.
  always_comb begin
    stateNext     = state;
    highPhaseNext = highPhase;
    bitCountNext  = bitCount;
    shiftNext     = shiftReg;
    unique case (state)
      IDLE: begin
        if (host.start) begin
          stateNext     = CLEAR;
          highPhaseNext = 1'b0;
          bitCountNext  = '0;
          shiftNext     = frameBits;
        end
      end
      CLEAR: begin
        if (halfPeriodTick) begin
          if (highPhase) begin
            stateNext     = SHIFT;
            highPhaseNext = 1'b0;
          end else begin
            highPhaseNext = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (halfPeriodTick) begin
          if (!highPhase) begin
            highPhaseNext = 1'b1;
          end else begin
            highPhaseNext = 1'b0;
            shiftNext     = shiftReg << 1;
            bitCountNext  = bitCount + 1'b1;
            if (bitCount == lastBit) begin
              stateNext = DONE;
            end
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign restart = (stateNext != state);

  // Link outputs are registered from the next-state values so they line up
  // with the state they belong to rather than lagging it by a cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      highPhase   <= 1'b0;
      bitCount    <= '0;
      shiftReg    <= '0;
      serialReset <= 1'b0;
      serialClock <= 1'b0;
      serialData  <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      state       <= stateNext;
      highPhase   <= highPhaseNext;
      bitCount    <= bitCountNext;
      shiftReg    <= shiftNext;
      serialReset <= (stateNext == CLEAR);
      serialClock <= (stateNext == SHIFT) && highPhaseNext;
      serialData  <= (stateNext == SHIFT) ? shiftNext[numInputs-1] : 1'b0;
      doneReg     <= (stateNext == DONE);
    end
  end

  assign host.ready = (state == IDLE);
  assign host.busy  = (state != IDLE);
  assign host.done  = doneReg;

endmodule

// File: tb/tb_serial_image_transmitter.sv
module tb_serial_image_transmitter;
  import nn_serial_pkg::*;

  logic clk;
  logic rst;

  serial_image_transmitter_if #(.numInputs(8), .dataWidth(16)) smallIf ();
  serial_image_transmitter_if #(.numInputs(784), .dataWidth(16)) bigIf ();

  logic sRstS, sClkS, sDataS;
  logic sRstB, sClkB, sDataB;

  serial_image_transmitter #(.numInputs(8), .clkDiv(2)) dutSmall (
    .clock       (clk),
    .reset       (rst),
    .host        (smallIf),
    .serialReset (sRstS),
    .serialClock (sClkS),
    .serialData  (sDataS)
  );

  serial_image_transmitter #(.numInputs(784), .clkDiv(1)) dutBig (
    .clock       (clk),
    .reset       (rst),
    .host        (bigIf),
    .serialReset (sRstB),
    .serialClock (sClkB),
    .serialData  (sDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver models: shift left on serialClock rise, inserting at bit 0.
  logic [7:0]   rxS;
  logic [783:0] rxB;
  always @(posedge sClkS or posedge sRstS) begin
    if (sRstS) rxS <= '0;
    else       rxS <= {rxS[6:0], sDataS};
  end
  always @(posedge sClkB or posedge sRstB) begin
    if (sRstB) rxB <= '0;
    else       rxB <= {rxB[782:0], sDataB};
  end

  int edgesS = 0;
  int edgesB = 0;
  int doneCntS = 0;
  int doneCntB = 0;
  always @(posedge sClkS) edgesS++;
  always @(posedge sClkB) edgesB++;
  always @(posedge clk) if (smallIf.done === 1'b1) doneCntS++;
  always @(posedge clk) if (bigIf.done === 1'b1) doneCntB++;

  // Data must hold steady in any cycle where the link clock is high.
  int   viol = 0;
  logic prevDataS = 1'b0;
  logic prevDataB = 1'b0;
  always @(negedge clk) begin
    if (sClkS === 1'b1 && sDataS !== prevDataS) viol++;
    if (sClkB === 1'b1 && sDataB !== prevDataB) viol++;
    prevDataS = sDataS;
    prevDataB = sDataB;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkIdleSmall(input string tag);
    check({tag, ".ready"}, 64'(smallIf.ready), 64'd1);
    check({tag, ".busy"}, 64'(smallIf.busy), 64'd0);
    check({tag, ".done"}, 64'(smallIf.done), 64'd0);
    check({tag, ".serialClock"}, 64'(sClkS), 64'd0);
    check({tag, ".serialData"}, 64'(sDataS), 64'd0);
    check({tag, ".serialReset"}, 64'(sRstS), 64'd0);
  endtask

  task automatic runSmall(input logic [127:0] pix, input bit disturb,
                          output int lat, output int edges, output int dones);
    int e0, d0, n;
    e0 = edgesS;
    d0 = doneCntS;
    @(negedge clk);
    smallIf.start  = 1'b1;
    smallIf.dataIn = pix;
    @(negedge clk);
    smallIf.start = 1'b0;
    n = 1;
    while (smallIf.done !== 1'b1 && n < 200) begin
      if (disturb && n == 2) smallIf.dataIn = {8{16'h0100}};
      if (disturb && n == 5) begin
        check("busyWhileShifting", 64'(smallIf.busy), 64'd1);
        smallIf.start = 1'b1;
      end
      if (disturb && n == 6) smallIf.start = 1'b0;
      @(negedge clk);
      n++;
    end
    lat = n;
    @(negedge clk);
    check("readyAfterDone", 64'(smallIf.ready), 64'd1);
    repeat (3) @(negedge clk);
    edges = edgesS - e0;
    dones = doneCntS - d0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] pix;
    logic [7:0]   bits;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, edges, dones, n, e0;
    logic [783:0] allOnes;

    vecs[0] = '{"loopback", 128'h0100_0000_0100_0100_0000_0000_0100_0000, 8'hB2};
    vecs[1] = '{"threshold", 128'h0000_0080_8000_7FFF_0100_FF80_0080_007F, 8'h5A};
    vecs[2] = '{"allOne", {8{16'h0100}}, 8'hFF};
    vecs[3] = '{"mixed", 128'hFFFF_0081_7F00_007F_0000_8001_0080_0200, 8'h63};

    rst = 1'b1;
    smallIf.start = 1'b0;
    smallIf.dataIn = '0;
    bigIf.start = 1'b0;
    bigIf.dataIn = '0;

    repeat (3) @(negedge clk);
    checkIdleSmall("reset");
    check("reset.big.ready", 64'(bigIf.ready), 64'd1);
    check("reset.big.serialClock", 64'(sClkB), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkIdleSmall("idle");

    for (int i = 0; i < 4; i++) begin
      runSmall(vecs[i].pix, 1'b0, lat, edges, dones);
      check({vecs[i].name, ".rx"}, 64'(rxS), 64'(vecs[i].bits));
      check({vecs[i].name, ".doneCycle"}, 64'(lat), 64'd37);
      check({vecs[i].name, ".edges"}, 64'(edges), 64'd8);
      check({vecs[i].name, ".donePulses"}, 64'(dones), 64'd1);
    end

    // Second start and dataIn change while busy must not disturb the frame.
    runSmall(vecs[0].pix, 1'b1, lat, edges, dones);
    check("handshake.rx", 64'(rxS), 64'hB2);
    check("handshake.doneCycle", 64'(lat), 64'd37);
    check("handshake.edges", 64'(edges), 64'd8);
    check("handshake.donePulses", 64'(dones), 64'd1);
    repeat (40) @(negedge clk);
    check("handshake.noRestart", 64'(smallIf.ready), 64'd1);

    // Reset while bit 3 is in its high phase (cycles 19..20).
    @(negedge clk);
    smallIf.start  = 1'b1;
    smallIf.dataIn = vecs[2].pix;
    @(negedge clk);
    smallIf.start = 1'b0;
    n = 1;
    while (n < 19) begin
      @(negedge clk);
      n++;
    end
    check("midReset.bit3High", 64'(sClkS), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleSmall("midReset");
    runSmall(vecs[3].pix, 1'b0, lat, edges, dones);
    check("afterReset.rx", 64'(rxS), 64'h63);
    check("afterReset.doneCycle", 64'(lat), 64'd37);
    check("afterReset.edges", 64'(edges), 64'd8);

    // Full-size frame with clkDiv=1.
    allOnes = '1;
    e0 = edgesB;
    @(negedge clk);
    bigIf.start  = 1'b1;
    bigIf.dataIn = {784{16'h0100}};
    @(negedge clk);
    bigIf.start = 1'b0;
    n = 1;
    while (bigIf.done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("big.doneCycle", 64'(n), 64'd1571);
    @(negedge clk);
    check("big.readyAfterDone", 64'(bigIf.ready), 64'd1);
    check("big.edges", 64'(edgesB - e0), 64'd784);
    check("big.rxAllOnes", 64'(rxB === allOnes), 64'd1);
    check("big.donePulses", 64'(doneCntB), 64'd1);

    check("dataStableWhileClockHigh", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
